// File: rtl/feature_pack_writer_if.sv
// Feature stream in / packed slot write out bundle for feature_pack_writer.
// master = the packer (accepts features, drives slot writes); slave = upstream source plus slot.
interface feature_pack_writer_if #(
  parameter int WRITE_WIDTH = 64,
  parameter int WRITE_DEPTH = 512,
  parameter int READ_WIDTH  = 32,
  parameter int READ_DEPTH  = 1024
);
  localparam int ADDR_W  = $clog2(WRITE_DEPTH);
  localparam int COUNT_W = $clog2(READ_DEPTH);

  logic                   in_valid;
  logic                   in_ready;
  logic [READ_WIDTH-1:0]  in_feature;
  logic                   in_last;
  logic [COUNT_W-1:0]     feature_count;
  logic                   write_enable;
  logic [ADDR_W-1:0]      write_address;
  logic [WRITE_WIDTH-1:0] write_data;
  logic                   packet_done;

  modport master (
    input  in_valid, in_feature, in_last, feature_count,
    output in_ready, write_enable, write_address, write_data, packet_done
  );

  modport slave (
    output in_valid, in_feature, in_last, feature_count,
    input  in_ready, write_enable, write_address, write_data, packet_done
  );
endinterface

// File: rtl/feature_pack_writer.sv
// Packs pairs of READ_WIDTH features into WRITE_WIDTH slot words (low half = first feature).
// Optional word counter on stat_words enabled by macro FEATURE_PACK_WRITER_STATS_EN.
module feature_pack_writer #(
  parameter int WRITE_WIDTH = 64,
  parameter int WRITE_DEPTH = 512,
  parameter int READ_WIDTH  = 32,
  parameter int READ_DEPTH  = 1024
) (
  input  logic                  core_clk,
  input  logic                  resetn,
  feature_pack_writer_if.master fp,
  output logic [31:0]           stat_words
);
  localparam int ADDR_W  = $clog2(WRITE_DEPTH);
  localparam int COUNT_W = $clog2(READ_DEPTH);
  // Four-feature margin covers the slot's one-cycle occupancy update lag.
  localparam logic [COUNT_W-1:0] SPACE_LIMIT = COUNT_W'(READ_DEPTH - 4);
  localparam logic [ADDR_W-1:0]  ADDR_LAST   = ADDR_W'(WRITE_DEPTH - 1);

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_HALF  = 1'b1
  } state_t;

  state_t                 state_reg, state_next;
  logic [READ_WIDTH-1:0]  held_reg, held_next;
  logic                   write_enable_reg, write_enable_next;
  logic                   packet_done_reg, packet_done_next;
  logic [WRITE_WIDTH-1:0] write_data_reg, write_data_next;
  logic [ADDR_W-1:0]      write_address_reg;

  logic space_ok;
  logic ready_c;
  logic transfer;

  assign space_ok = !write_enable_reg && (fp.feature_count <= SPACE_LIMIT);
  // Only a beat that would complete a word needs slot space; a first half can always be held.
  assign ready_c  = resetn && (((state_reg == ST_HALF) || fp.in_last) ? space_ok : 1'b1);
  assign transfer = fp.in_valid && ready_c;

  always_ff @(posedge core_clk or negedge resetn) begin
    if (!resetn) begin
      state_reg         <= ST_EMPTY;
      held_reg          <= '0;
      write_enable_reg  <= 1'b0;
      packet_done_reg   <= 1'b0;
      write_data_reg    <= '0;
      write_address_reg <= '0;
    end else begin
      state_reg        <= state_next;
      held_reg         <= held_next;
      write_enable_reg <= write_enable_next;
      packet_done_reg  <= packet_done_next;
      write_data_reg   <= write_data_next;
      if (write_enable_reg) begin
        write_address_reg <= (write_address_reg == ADDR_LAST) ? '0 : write_address_reg + 1'b1;
      end
    end
  end

  always_comb begin
    state_next        = state_reg;
    held_next         = held_reg;
    write_enable_next = 1'b0;
    packet_done_next  = 1'b0;
    write_data_next   = write_data_reg;
    unique case (state_reg)
      ST_EMPTY: begin
        if (transfer) begin
          if (fp.in_last) begin
            write_enable_next = 1'b1;
            packet_done_next  = 1'b1;
            write_data_next   = {{READ_WIDTH{1'b0}}, fp.in_feature};
          end else begin
            held_next  = fp.in_feature;
            state_next = ST_HALF;
          end
        end
      end
      ST_HALF: begin
        if (transfer) begin
          write_enable_next = 1'b1;
          packet_done_next  = fp.in_last;
          write_data_next   = {fp.in_feature, held_reg};
          state_next        = ST_EMPTY;
        end
      end
      default: state_next = ST_EMPTY;
    endcase
  end

  assign fp.in_ready      = ready_c;
  assign fp.write_enable  = write_enable_reg;
  assign fp.write_address = write_address_reg;
  assign fp.write_data    = write_data_reg;
  assign fp.packet_done   = packet_done_reg;

`ifdef FEATURE_PACK_WRITER_STATS_EN
  logic [31:0] stat_words_reg;

  always_ff @(posedge core_clk or negedge resetn) begin
    if (!resetn) begin
      stat_words_reg <= '0;
    end else if (write_enable_reg && (stat_words_reg != 32'hFFFF_FFFF)) begin
      stat_words_reg <= stat_words_reg + 32'd1;
    end
  end

  assign stat_words = stat_words_reg;
`else
  assign stat_words = 32'd0;
`endif
endmodule

// File: tb/tb_feature_pack_writer.sv
// Directed self-checking bench for feature_pack_writer (default 64/512/32/1024 geometry).
module tb_feature_pack_writer;
  logic        core_clk = 1'b0;
  logic        resetn   = 1'b0;
  logic [31:0] stat_words;
  int          n_cmp    = 0;
  int          n_fail   = 0;

  feature_pack_writer_if #(.WRITE_WIDTH(64), .WRITE_DEPTH(512), .READ_WIDTH(32), .READ_DEPTH(1024)) bus ();

  feature_pack_writer #(.WRITE_WIDTH(64), .WRITE_DEPTH(512), .READ_WIDTH(32), .READ_DEPTH(1024)) dut (
    .core_clk   (core_clk),
    .resetn     (resetn),
    .fp         (bus.master),
    .stat_words (stat_words)
  );

  always #5 core_clk = ~core_clk;

  task automatic tick();
    @(posedge core_clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.in_valid      = 1'b0;
    bus.in_feature    = '0;
    bus.in_last       = 1'b0;
    bus.feature_count = '0;
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    tick();
    tick();
    resetn = 1'b1;
  endtask

  task automatic test_reset();
    idle_inputs();
    resetn = 1'b0;
    tick();
    @(negedge core_clk);
    n_cmp++; if (bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL reset_ready got=%b want=0", bus.in_ready); end
    n_cmp++; if (bus.write_enable !== 1'b0) begin n_fail++; $display("FAIL reset_we got=%b want=0", bus.write_enable); end
    n_cmp++; if (bus.packet_done !== 1'b0) begin n_fail++; $display("FAIL reset_pd got=%b want=0", bus.packet_done); end
    n_cmp++; if (bus.write_address !== 9'd0) begin n_fail++; $display("FAIL reset_addr got=%0d want=0", bus.write_address); end
    n_cmp++; if (bus.write_data !== 64'd0) begin n_fail++; $display("FAIL reset_data got=%h want=0", bus.write_data); end
    n_cmp++; if (stat_words !== 32'd0) begin n_fail++; $display("FAIL reset_stat got=%0d want=0", stat_words); end
    tick();
    resetn = 1'b1;
    @(negedge core_clk);
    n_cmp++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL post_reset_ready got=%b want=1", bus.in_ready); end
    $display("test_reset: done");
  endtask

  task automatic test_pair();
    tick();
    bus.in_valid = 1'b1; bus.in_feature = 32'h11; bus.in_last = 1'b0; bus.feature_count = '0;
    tick();
    bus.in_feature = 32'h22;
    @(negedge core_clk);
    n_cmp++; if (bus.write_enable !== 1'b0) begin n_fail++; $display("FAIL pair_no_early_write got=%b want=0", bus.write_enable); end
    n_cmp++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL pair_half_ready got=%b want=1", bus.in_ready); end
    tick();
    idle_inputs();
    @(negedge core_clk);
    n_cmp++; if (bus.write_enable !== 1'b1) begin n_fail++; $display("FAIL pair_we got=%b want=1", bus.write_enable); end
    n_cmp++; if (bus.write_address !== 9'd0) begin n_fail++; $display("FAIL pair_addr got=%0d want=0", bus.write_address); end
    n_cmp++; if (bus.write_data !== 64'h00000022_00000011) begin n_fail++; $display("FAIL pair_data got=%h want=0000002200000011", bus.write_data); end
    n_cmp++; if (bus.packet_done !== 1'b0) begin n_fail++; $display("FAIL pair_pd got=%b want=0", bus.packet_done); end
    tick();
    @(negedge core_clk);
    n_cmp++; if (bus.write_enable !== 1'b0) begin n_fail++; $display("FAIL pair_we_one_cycle got=%b want=0", bus.write_enable); end
    n_cmp++; if (bus.write_data !== 64'h00000022_00000011) begin n_fail++; $display("FAIL pair_data_hold got=%h want=0000002200000011", bus.write_data); end
    n_cmp++; if (bus.write_address !== 9'd1) begin n_fail++; $display("FAIL pair_addr_adv got=%0d want=1", bus.write_address); end
    $display("test_pair: done");
  endtask

  task automatic test_single_last();
    tick();
    bus.in_valid = 1'b1; bus.in_feature = 32'hAB; bus.in_last = 1'b1; bus.feature_count = '0;
    @(negedge core_clk);
    n_cmp++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL single_ready got=%b want=1", bus.in_ready); end
    tick();
    idle_inputs();
    bus.feature_count = 10'd1021;
    @(negedge core_clk);
    n_cmp++; if (bus.write_enable !== 1'b1) begin n_fail++; $display("FAIL single_we got=%b want=1", bus.write_enable); end
    n_cmp++; if (bus.write_data !== 64'h00000000_000000AB) begin n_fail++; $display("FAIL single_data got=%h want=00000000000000ab", bus.write_data); end
    n_cmp++; if (bus.packet_done !== 1'b1) begin n_fail++; $display("FAIL single_pd got=%b want=1", bus.packet_done); end
    n_cmp++; if (bus.write_address !== 9'd1) begin n_fail++; $display("FAIL single_addr got=%0d want=1", bus.write_address); end
    // A non-last beat is still accepted when full only if nothing is held (EMPTY).
    n_cmp++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL single_stays_empty got=%b want=1", bus.in_ready); end
    bus.feature_count = '0;
    $display("test_single_last: done");
  endtask

  task automatic test_backpressure();
    tick();
    bus.in_valid = 1'b1; bus.in_feature = 32'h33; bus.in_last = 1'b0; bus.feature_count = '0;
    tick();
    bus.in_feature = 32'h44; bus.feature_count = 10'd1021;
    @(negedge core_clk);
    n_cmp++; if (bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_ready_1021 got=%b want=0", bus.in_ready); end
    tick();
    @(negedge core_clk);
    n_cmp++; if (bus.write_enable !== 1'b0) begin n_fail++; $display("FAIL bp_no_write got=%b want=0", bus.write_enable); end
    n_cmp++; if (bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_still_stalled got=%b want=0", bus.in_ready); end
    bus.feature_count = 10'd1020;
    #1;
    n_cmp++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_ready_1020 got=%b want=1", bus.in_ready); end
    tick();
    idle_inputs();
    @(negedge core_clk);
    n_cmp++; if (bus.write_enable !== 1'b1) begin n_fail++; $display("FAIL bp_we got=%b want=1", bus.write_enable); end
    n_cmp++; if (bus.write_data !== 64'h00000044_00000033) begin n_fail++; $display("FAIL bp_data got=%h want=0000004400000033", bus.write_data); end
    n_cmp++; if (bus.write_address !== 9'd2) begin n_fail++; $display("FAIL bp_addr got=%0d want=2", bus.write_address); end
    $display("test_backpressure: done");
  endtask

  task automatic test_back_to_back();
    tick();
    bus.in_valid = 1'b1; bus.in_feature = 32'h61; bus.in_last = 1'b0; bus.feature_count = '0;
    tick();
    bus.in_feature = 32'h62;
    @(negedge core_clk);
    n_cmp++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_ready_half got=%b want=1", bus.in_ready); end
    tick();
    bus.in_feature = 32'h63; bus.in_last = 1'b1;
    @(negedge core_clk);
    n_cmp++; if (bus.write_data !== 64'h00000062_00000061) begin n_fail++; $display("FAIL b2b_data1 got=%h want=0000006200000061", bus.write_data); end
    n_cmp++; if (bus.write_address !== 9'd3) begin n_fail++; $display("FAIL b2b_addr1 got=%0d want=3", bus.write_address); end
    n_cmp++; if (bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL b2b_blocked_by_write got=%b want=0", bus.in_ready); end
    tick();
    @(negedge core_clk);
    n_cmp++; if (bus.write_enable !== 1'b0) begin n_fail++; $display("FAIL b2b_gap got=%b want=0", bus.write_enable); end
    n_cmp++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_ready_again got=%b want=1", bus.in_ready); end
    tick();
    idle_inputs();
    @(negedge core_clk);
    n_cmp++; if (bus.write_data !== 64'h00000000_00000063) begin n_fail++; $display("FAIL b2b_data2 got=%h want=0000000000000063", bus.write_data); end
    n_cmp++; if (bus.packet_done !== 1'b1) begin n_fail++; $display("FAIL b2b_pd got=%b want=1", bus.packet_done); end
    n_cmp++; if (bus.write_address !== 9'd4) begin n_fail++; $display("FAIL b2b_addr2 got=%0d want=4", bus.write_address); end
    $display("test_back_to_back: done");
  endtask

  task automatic test_wrap();
    logic [8:0]  exp_addr;
    logic [63:0] exp_data;
    logic [31:0] exp_stat;
    int          bad = 0;
    idle_inputs();
    do_reset();
    bus.in_valid = 1'b1;
    for (int k = 0; k < 1026; k++) begin
      bus.in_feature = 32'(k);
      tick();
      if ((k % 2) == 1) begin
        exp_addr = 9'((k / 2) % 512);
        exp_data = {32'(k), 32'(k - 1)};
        n_cmp++;
        if (bus.write_enable !== 1'b1 || bus.write_address !== exp_addr || bus.write_data !== exp_data) begin
          n_fail++; bad++;
          if (bad <= 4) $display("FAIL wrap_write%0d got we=%b addr=%0d data=%h want we=1 addr=%0d data=%h",
                                 k / 2, bus.write_enable, bus.write_address, bus.write_data, exp_addr, exp_data);
        end
      end
    end
    idle_inputs();
    tick();
`ifdef FEATURE_PACK_WRITER_STATS_EN
    exp_stat = 32'd513;
`else
    exp_stat = 32'd0;
`endif
    @(negedge core_clk);
    n_cmp++; if (stat_words !== exp_stat) begin n_fail++; $display("FAIL wrap_stat got=%0d want=%0d", stat_words, exp_stat); end
    n_cmp++; if (bus.write_address !== 9'd1) begin n_fail++; $display("FAIL wrap_next_addr got=%0d want=1", bus.write_address); end
    $display("test_wrap: done");
  endtask

  task automatic test_reset_mid_packet();
    tick();
    bus.in_valid = 1'b1; bus.in_feature = 32'h55; bus.in_last = 1'b0; bus.feature_count = '0;
    tick();
    idle_inputs();
    resetn = 1'b0;
    @(negedge core_clk);
    n_cmp++; if (bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL mid_reset_ready got=%b want=0", bus.in_ready); end
    n_cmp++; if (bus.write_data !== 64'd0) begin n_fail++; $display("FAIL mid_reset_data got=%h want=0", bus.write_data); end
    n_cmp++; if (stat_words !== 32'd0) begin n_fail++; $display("FAIL mid_reset_stat got=%0d want=0", stat_words); end
    tick();
    resetn = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge core_clk);
      n_cmp++; if (bus.write_enable !== 1'b0) begin n_fail++; $display("FAIL mid_no_partial%0d got=%b want=0", c, bus.write_enable); end
      tick();
    end
    bus.in_valid = 1'b1; bus.in_feature = 32'h66;
    tick();
    bus.in_feature = 32'h77;
    tick();
    idle_inputs();
    @(negedge core_clk);
    n_cmp++; if (bus.write_enable !== 1'b1) begin n_fail++; $display("FAIL mid_pair_we got=%b want=1", bus.write_enable); end
    n_cmp++; if (bus.write_address !== 9'd0) begin n_fail++; $display("FAIL mid_pair_addr got=%0d want=0", bus.write_address); end
    n_cmp++; if (bus.write_data !== 64'h00000077_00000066) begin n_fail++; $display("FAIL mid_pair_data got=%h want=0000007700000066", bus.write_data); end
    $display("test_reset_mid_packet: done");
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_pair();
    test_single_last();
    test_backpressure();
    test_back_to_back();
    test_wrap();
    test_reset_mid_packet();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
